voltage_monitor: RTL and testbench

//  Consumes the registered 8-bit converter voltage word from the data collection stage.

---
 rtl/voltage_monitor_pkg.sv | 22 ++
 rtl/sample_prescaler.sv | 27 ++
 rtl/voltage_monitor.sv | 133 +++++++++++++
 tb/tb_voltage_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/voltage_monitor_pkg.sv
// Shared types and defaults for the voltage monitor: alarm states, threshold
// defaults and the accumulator width helper.
package voltage_monitor_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        OVER   = 2'd1,
        UNDER  = 2'd2
    } alarm_state_t;

    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_LOG2_WIN   = 3;
    localparam int DEF_OV_TH      = 200;
    localparam int DEF_UV_TH      = 50;
    localparam int DEF_HYST       = 8;

    // Holds the sum of a full window of 8-bit samples without overflow
    function automatic int acc_w(input int log2_win);
        return 8 + log2_win;
    endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Free-running divide-by-SAMPLE_DIV counter: take marks the sampling cycle,
// tick is its registered echo one cycle later.
module sample_prescaler #(
    parameter int SAMPLE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic take,
    output logic tick
);
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign take = (cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= take ? '0 : cnt + 1'b1;
            tick <= take;
        end
    end

endmodule

// File: rtl/voltage_monitor.sv
// Decimated voltage monitor: windowed avg/min/max over a valid/ready handshake
// plus an over/under-voltage alarm FSM with release hysteresis.
module voltage_monitor
    import voltage_monitor_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int LOG2_WIN   = DEF_LOG2_WIN,
    parameter int OV_TH      = DEF_OV_TH,
    parameter int UV_TH      = DEF_UV_TH,
    parameter int HYST       = DEF_HYST
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       stats_ready,
    output logic       sample_tick,
    output logic       stats_valid,
    output logic [7:0] avg_out,
    output logic [7:0] min_out,
    output logic [7:0] max_out,
    output logic       overrun,
    output logic       ov_alarm,
    output logic       uv_alarm
);
    localparam int ACC_W = acc_w(LOG2_WIN);

    localparam logic [7:0] OV_LVL = 8'(OV_TH);
    localparam logic [7:0] OV_REL = 8'(OV_TH - HYST);
    localparam logic [7:0] UV_LVL = 8'(UV_TH);
    localparam logic [7:0] UV_REL = 8'(UV_TH + HYST);

    logic take;

    sample_prescaler #(.SAMPLE_DIV(SAMPLE_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .take  (take),
        .tick  (sample_tick)
    );

    // ---------------- window statistics ----------------
    logic [ACC_W-1:0]    acc;
    logic [LOG2_WIN-1:0] samp_cnt;
    logic [7:0]          run_min, run_max;
    logic [ACC_W-1:0]    sum_now;
    logic [7:0]          min_now, max_now, avg_now;
    logic                load, xfer;

    assign sum_now = acc + ACC_W'(data_in);
    assign min_now = (data_in < run_min) ? data_in : run_min;
    assign max_now = (data_in > run_max) ? data_in : run_max;
    assign avg_now = 8'(sum_now >> LOG2_WIN);
    assign load    = take && (&samp_cnt);
    assign xfer    = stats_valid && stats_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            samp_cnt <= '0;
            run_min  <= 8'hFF;
            run_max  <= 8'h00;
        end else if (take) begin
            samp_cnt <= samp_cnt + 1'b1;
            // Closing sample goes straight into the result; running state restarts
            if (load) begin
                acc     <= '0;
                run_min <= 8'hFF;
                run_max <= 8'h00;
            end else begin
                acc     <= sum_now;
                run_min <= min_now;
                run_max <= max_now;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stats_valid <= 1'b0;
            avg_out     <= '0;
            min_out     <= '0;
            max_out     <= '0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                avg_out     <= avg_now;
                min_out     <= min_now;
                max_out     <= max_now;
                stats_valid <= 1'b1;
            end else if (xfer) begin
                stats_valid <= 1'b0;
            end
            // A transfer in the same cycle as a load means nothing was lost
            if (xfer)
                overrun <= 1'b0;
            else if (load && stats_valid)
                overrun <= 1'b1;
        end
    end

    // ---------------- alarm FSM ----------------
    alarm_state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= NORMAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (take) begin
            case (state_q)
                NORMAL: begin
                    if (data_in > OV_LVL)      state_d = OVER;
                    else if (data_in < UV_LVL) state_d = UNDER;
                end
                OVER: begin
                    if (data_in < UV_LVL)      state_d = UNDER;
                    else if (data_in < OV_REL) state_d = NORMAL;
                end
                UNDER: begin
                    if (data_in > OV_LVL)      state_d = OVER;
                    else if (data_in > UV_REL) state_d = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    assign ov_alarm = (state_q == OVER);
    assign uv_alarm = (state_q == UNDER);

endmodule

// File: tb/tb_voltage_monitor.sv
// Directed bench: window stats, handshake/overrun, alarm hysteresis, reset
// mid-window, and first-tick latency with SAMPLE_DIV=4.
module tb_voltage_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       stats_ready = 1'b0;
    logic       sample_tick, stats_valid, overrun, ov_alarm, uv_alarm;
    logic [7:0] avg_out, min_out, max_out;

    logic       reset4 = 1'b1;
    logic       tick4, valid4, ovr4, ov4, uv4;
    logic [7:0] avg4, min4, max4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    voltage_monitor #(.SAMPLE_DIV(1), .LOG2_WIN(3), .OV_TH(200), .UV_TH(50), .HYST(8)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .stats_ready(stats_ready),
        .sample_tick(sample_tick), .stats_valid(stats_valid), .avg_out(avg_out),
        .min_out(min_out), .max_out(max_out), .overrun(overrun),
        .ov_alarm(ov_alarm), .uv_alarm(uv_alarm)
    );

    voltage_monitor #(.SAMPLE_DIV(4), .LOG2_WIN(3), .OV_TH(200), .UV_TH(50), .HYST(8)) u_dut4 (
        .clk(clk), .reset(reset4), .data_in(8'd77), .stats_ready(1'b1),
        .sample_tick(tick4), .stats_valid(valid4), .avg_out(avg4),
        .min_out(min4), .max_out(max4), .overrun(ovr4),
        .ov_alarm(ov4), .uv_alarm(uv4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample per edge (SAMPLE_DIV=1); outputs settle #1 after the edge
    task automatic feed(input int v);
        data_in = 8'(v);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"},  int'(sample_tick), 0);
        chk({tag, "_valid"}, int'(stats_valid), 0);
        chk({tag, "_avg"},   int'(avg_out), 0);
        chk({tag, "_min"},   int'(min_out), 0);
        chk({tag, "_max"},   int'(max_out), 0);
        chk({tag, "_ovr"},   int'(overrun), 0);
        chk({tag, "_ov"},    int'(ov_alarm), 0);
        chk({tag, "_uv"},    int'(uv_alarm), 0);
    endtask

    initial begin
        int ov_exp[5] = '{0, 1, 1, 0, 0};
        int ov_smp[5] = '{150, 201, 195, 191, 150};
        int t5_smp[5] = '{49, 210, 40, 58, 59};
        int t5_uv[5]  = '{1, 0, 1, 1, 0};
        int t5_ov[5]  = '{0, 1, 0, 0, 0};

        // Reset state
        #1;
        chk_all_zero("rst");
        do_reset();

        // 1: one window, ready high
        stats_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            feed(i * 10);
            if (i < 8) chk("t1_valid_early", int'(stats_valid), 0);
        end
        chk("t1_tick",  int'(sample_tick), 1);
        chk("t1_valid", int'(stats_valid), 1);
        chk("t1_avg",   int'(avg_out), 45);
        chk("t1_min",   int'(min_out), 10);
        chk("t1_max",   int'(max_out), 80);
        feed(100);
        chk("t1_drop",  int'(stats_valid), 0);

        // 2: two windows unconsumed -> overwrite + overrun
        do_reset();
        stats_ready = 1'b0;
        for (int i = 1; i <= 8; i++) feed(i * 10);
        chk("t2_w1_avg", int'(avg_out), 45);
        for (int i = 2; i <= 9; i++) begin
            feed(i * 10);
            if (i == 5) begin
                chk("t2_hold_avg", int'(avg_out), 45);
                chk("t2_hold_max", int'(max_out), 80);
            end
        end
        chk("t2_valid", int'(stats_valid), 1);
        chk("t2_ovr",   int'(overrun), 1);
        chk("t2_avg",   int'(avg_out), 55);
        chk("t2_min",   int'(min_out), 20);
        chk("t2_max",   int'(max_out), 90);
        stats_ready = 1'b1;
        feed(100);
        chk("t2_xfer_valid", int'(stats_valid), 0);
        chk("t2_xfer_ovr",   int'(overrun), 0);

        // 3: transfer coincides with the next window load
        do_reset();
        stats_ready = 1'b0;
        for (int i = 1; i <= 8; i++) feed(i * 10);
        for (int i = 1; i <= 7; i++) feed(100);
        stats_ready = 1'b1;
        feed(100);
        chk("t3_valid", int'(stats_valid), 1);
        chk("t3_ovr",   int'(overrun), 0);
        chk("t3_avg",   int'(avg_out), 100);
        feed(0);
        chk("t3_drop",  int'(stats_valid), 0);

        // 4: over-voltage trip and hysteresis release
        do_reset();
        for (int i = 0; i < 5; i++) begin
            feed(ov_smp[i]);
            chk($sformatf("t4_ov_%0d", ov_smp[i]), int'(ov_alarm), ov_exp[i]);
        end

        // 5: under -> over directly, under hysteresis
        do_reset();
        for (int i = 0; i < 5; i++) begin
            feed(t5_smp[i]);
            chk($sformatf("t5_uv_%0d", t5_smp[i]), int'(uv_alarm), t5_uv[i]);
            chk($sformatf("t5_ov_%0d", t5_smp[i]), int'(ov_alarm), t5_ov[i]);
        end

        // 6: asynchronous reset mid-window
        do_reset();
        stats_ready = 1'b0;
        for (int i = 0; i < 5; i++) feed(255);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t6_async");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) feed(8);
        chk("t6_valid_7", int'(stats_valid), 0);
        feed(8);
        chk("t6_valid_8", int'(stats_valid), 1);
        chk("t6_avg",     int'(avg_out), 8);
        chk("t6_max",     int'(max_out), 8);
        chk("t6_min",     int'(min_out), 8);

        // 6b: SAMPLE_DIV=4 first tick on cycle 4 after reset release
        chk("t6b_rst_tick", int'(tick4), 0);
        reset4 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t6b_tick_c%0d", c), int'(tick4), (c == 4) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
